// File: rtl/tb_pkg.sv
// tb_pkg: shared state encoding, counter width and saturating add for the result scoreboard.
package tb_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int CNT_W = 16;
    localparam int DEF_DATA_W = 32;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/tb_sync_fifo.sv
// tb_sync_fifo: expected-data FIFO; a push into a full FIFO is accepted only alongside a real pop.
module tb_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              drop,
    output logic [DATA_W-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic [DATA_W-1:0] mem [DEPTH];
    logic rd, wr, bypass;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd = pop & ~empty;
    // push and pop against an empty FIFO pass straight through without storage
    assign bypass = push & pop & empty;
    assign wr = push & ~bypass & (~full | rd);
    assign drop = push & full & ~rd;
    assign rd_data = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= wr_data;
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(wr);
            rp <= rp + (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/tb_scoreboard.sv
// tb_scoreboard: compares DUT output against queued expected data and ends the test on completion or failure.
module tb_scoreboard import tb_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = 16,
    parameter int NUM_TXN = 256,
    parameter int MAX_ERR = 4,
    parameter int DRAIN_TO = 64
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              stall,
    input  logic              cmp_on,
    input  logic              valid_off,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              act_valid,
    input  logic [DATA_W-1:0] act_data,
    output logic              stop_sim,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              exp_full,
    output logic              exp_ovf
);
    localparam int PW = $clog2(NUM_TXN + 1);
    localparam int TW = $clog2(DRAIN_TO + 1);
    state_t state, state_nx;
    logic [PW-1:0] push_cnt, push_nx;
    logic [TW-1:0] timer;
    logic push, pop, empty, drop, accept, checked, same, hit, miss, underflow, pass_set, fail_set;
    logic [DATA_W-1:0] head, ref_data;
    logic [CNT_W-1:0] err_nx, match_nx;

    assign push = exp_valid & ~valid_off & (state == IDLE || state == RUN);
    assign pop = act_valid & ~stall & (state == RUN || state == DRAIN);

    tb_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk(clk), .reset_(reset_), .push(push), .pop(pop), .wr_data(exp_data),
        .full(exp_full), .empty(empty), .drop(drop), .rd_data(head)
    );

    always_comb begin
        ref_data = empty ? exp_data : head;
        accept = push & ~drop;
        checked = pop & cmp_on & (~empty | push);
        same = ref_data == act_data;
        hit = checked & same;
        miss = checked & ~same;
        underflow = pop & empty & ~push;
        err_nx = sat_add(err_cnt, {1'b0, drop} + {1'b0, miss} + {1'b0, underflow});
        match_nx = sat_add(match_cnt, {1'b0, hit});
        push_nx = push_cnt + PW'(accept);
        state_nx = (state != DONE && err_nx >= CNT_W'(MAX_ERR)) ? DONE :
                   (state == IDLE && accept) ? RUN :
                   (state == RUN && push_nx >= PW'(NUM_TXN)) ? DRAIN :
                   (state == DRAIN && (empty || timer == TW'(DRAIN_TO - 1))) ? DONE : state;
        // a clean drain wins over a coincident timeout
        pass_set = state == DRAIN && empty && err_nx == '0;
        fail_set = state != DONE && state_nx == DONE && !pass_set;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            push_cnt <= '0;
            timer <= '0;
            err_cnt <= '0;
            match_cnt <= '0;
            exp_ovf <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            stop_sim <= 1'b0;
        end else begin
            state <= state_nx;
            push_cnt <= push_nx;
            timer <= (state == DRAIN) ? timer + 1'b1 : '0;
            err_cnt <= err_nx;
            match_cnt <= match_nx;
            exp_ovf <= exp_ovf | drop;
            pass <= pass | pass_set;
            fail <= fail | fail_set;
            stop_sim <= state_nx == DONE;
        end
    end
endmodule

// File: tb/tb_tb_scoreboard.sv
// tb_tb_scoreboard: directed checks of two scoreboard configurations driven by shared stimulus.
module tb_tb_scoreboard;
    import tb_pkg::*;
    logic clk = 1'b0, reset_ = 1'b0;
    logic stall = 1'b0, cmp_on = 1'b1, valid_off = 1'b0;
    logic exp_valid = 1'b0, act_valid = 1'b0;
    logic [31:0] exp_data = '0, act_data = '0;
    logic s0, p0, f0, full0, ovf0, s1, p1, f1, full1, ovf1;
    logic [15:0] e0, m0, e1, m1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    tb_scoreboard #(.DATA_W(32), .DEPTH(16), .NUM_TXN(8), .MAX_ERR(4), .DRAIN_TO(64)) u0 (
        .clk(clk), .reset_(reset_), .stall(stall), .cmp_on(cmp_on), .valid_off(valid_off),
        .exp_valid(exp_valid), .exp_data(exp_data), .act_valid(act_valid), .act_data(act_data),
        .stop_sim(s0), .pass(p0), .fail(f0), .err_cnt(e0), .match_cnt(m0), .exp_full(full0), .exp_ovf(ovf0)
    );
    tb_scoreboard #(.DATA_W(32), .DEPTH(4), .NUM_TXN(8), .MAX_ERR(2), .DRAIN_TO(8)) u1 (
        .clk(clk), .reset_(reset_), .stall(stall), .cmp_on(cmp_on), .valid_off(valid_off),
        .exp_valid(exp_valid), .exp_data(exp_data), .act_valid(act_valid), .act_data(act_data),
        .stop_sim(s1), .pass(p1), .fail(f1), .err_cnt(e1), .match_cnt(m1), .exp_full(full1), .exp_ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic ev, input logic [31:0] ed, input logic av, input logic [31:0] ad);
        exp_valid = ev;
        exp_data = ed;
        act_valid = av;
        act_data = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        cmp_on = 1'b1;
        exp_valid = 1'b0;
        act_valid = 1'b0;
        reset_ = 1'b0;
        @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_stop", 32'(s0), 0);
        chk("rst_pass", 32'(p0), 0);
        chk("rst_fail", 32'(f0), 0);
        chk("rst_err", 32'(e0), 0);
        chk("rst_match", 32'(m0), 0);
        chk("rst_full", 32'(full0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_state", 32'(u0.state), 32'(IDLE));

        // clean run: 8 pushes then 8 matching pops
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b0, '0);
        chk("t1_state_drain", 32'(u0.state), 32'(DRAIN));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 32'(i));
        chk("t1_match", 32'(m0), 8);
        chk("t1_stop_early", 32'(s0), 0);
        step(1'b0, '0, 1'b0, '0);
        chk("t1_stop", 32'(s0), 1);
        chk("t1_pass", 32'(p0), 1);
        chk("t1_fail", 32'(f0), 0);
        chk("t1_err", 32'(e0), 0);
        step(1'b1, 32'h7, 1'b1, 32'h7);
        chk("t1_frozen", 32'(m0), 8);

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, (i == 2) ? 32'hDEAD : 32'h10 + 32'(i));
        chk("t2_err", 32'(e0), 1);
        chk("t2_match", 32'(m0), 4);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h20 + 32'(i), 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h20 + 32'(i));
        chk("t2_stop_early", 32'(s0), 0);
        step(1'b0, '0, 1'b0, '0);
        chk("t2_fail", 32'(f0), 1);
        chk("t2_pass", 32'(p0), 0);
        chk("t2_stop", 32'(s0), 1);

        // overflow on the 4-deep instance
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 1), 1'b0, '0);
        chk("t3_full", 32'(full1), 1);
        chk("t3_ovf_pre", 32'(ovf1), 0);
        step(1'b1, 32'h5, 1'b0, '0);
        chk("t3_ovf", 32'(ovf1), 1);
        chk("t3_err", 32'(e1), 1);
        chk("t3_accepted", 32'(u1.push_cnt), 4);

        do_reset();
        step(1'b1, 32'h33, 1'b0, '0);
        cmp_on = 1'b0;
        step(1'b0, '0, 1'b1, 32'h99);
        cmp_on = 1'b1;
        chk("t4_discard_err", 32'(e0), 0);
        chk("t4_discard_match", 32'(m0), 0);
        step(1'b0, '0, 1'b1, '0);
        chk("t4_underflow", 32'(e0), 1);
        step(1'b1, 32'h55, 1'b1, 32'h55);
        chk("t4_bypass_match", 32'(m0), 1);
        chk("t4_bypass_empty", 32'(u0.empty), 1);
        chk("t4_bypass_accepted", 32'(u0.push_cnt), 2);

        // drain timeout with the DUT stalled
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0, '0);
        for (int i = 4; i < 8; i++) step(1'b1, 32'(i), 1'b1, 32'(i - 4));
        chk("t5_match", 32'(m1), 4);
        chk("t5_full", 32'(full1), 1);
        chk("t5_state", 32'(u1.state), 32'(DRAIN));
        stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, 1'b1, 32'h4);
            chk($sformatf("t5_stop_k%0d", k), 32'(s1), (k >= 8) ? 1 : 0);
        end
        stall = 1'b0;
        chk("t5_fail", 32'(f1), 1);
        chk("t5_pass", 32'(p1), 0);
        chk("t5_err", 32'(e1), 0);
        chk("t5_untouched", 32'(full1), 1);

        do_reset();
        step(1'b1, 32'hA, 1'b0, '0);
        step(1'b1, 32'hB, 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'hF0);
        chk("t6_err1", 32'(e1), 1);
        chk("t6_fail_early", 32'(f1), 0);
        step(1'b0, '0, 1'b1, 32'hF1);
        chk("t6_err2", 32'(e1), 2);
        chk("t6_fail", 32'(f1), 1);
        chk("t6_stop", 32'(s1), 1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("t6_rst_fail", 32'(f1), 0);
        chk("t6_rst_stop", 32'(s1), 0);
        chk("t6_rst_err", 32'(e1), 0);
        chk("t6_rst_match", 32'(m1), 0);
        chk("t6_rst_full", 32'(full1), 0);
        chk("t6_rst_state", 32'(u1.state), 32'(IDLE));
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
